// File: rtl/spi_pkg.sv
// Shared SPI register map, bit positions and frame-state encoding.
// Used by both the SPI target and the SPI master controller.
package spi_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_TXDATA = 8'h08;
  localparam logic [7:0] REG_RXDATA = 8'h0C;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_RX_IE    = 1;
  localparam int CTRL_RX_FLUSH = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_TX_EMPTY = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_UDR   = 5;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_ACTIVE
  } frame_state_e;

endpackage

// File: rtl/spi_target_rxfifo.sv
// Synchronous RX byte FIFO with push/pop/flush; flush has priority over both.
// Pop and push in the same cycle are both honoured, even when full.
module spi_target_rxfifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  input  logic       flush,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty && !flush;
    do_push  = push && !flush && (!full || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spi_target.sv
// SPI Mode 0 target: oversampled pins, byte shifter, frame FSM, RX FIFO and
// a memory-mapped register file with sticky overrun/underrun flags.
module spi_target
  import spi_pkg::*;
#(
  parameter int         RX_DEPTH  = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic [31:0] rdata,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  logic sck_meta_q, sck_sync_q, sck_dly_q;
  logic cs_meta_q, cs_sync_q, cs_dly_q;
  logic mosi_meta_q, mosi_sync_q;

  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]   rx_shift_q, rx_shift_d;
  logic [7:0]   tx_shift_q, tx_shift_d;
  logic [7:0]   tx_hold_q, tx_hold_d;
  logic         reload_q, reload_d, tx_pend_q, tx_pend_d;
  logic         en_q, en_d, rx_ie_q, rx_ie_d, rx_ovf_q, rx_ovf_d, tx_udr_q, tx_udr_d;

  logic       sck_rise, sck_fall, cs_fall, cs_rise, load;
  logic       ctrl_wr, status_wr, txdata_wr, rxdata_rd, flush, pop_fire;
  logic       push, fifo_full, fifo_empty;
  logic [7:0] push_data, fifo_head;
  logic       unused_ok;

  assign unused_ok = ^{req_wstrb, req_addr[31:8], req_wdata[31:8]};

  // Pins are asynchronous: two flops for metastability, a third for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_dly_q   <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_dly_q    <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sck_meta_q  <= spi_sck;
      sck_sync_q  <= sck_meta_q;
      sck_dly_q   <= sck_sync_q;
      cs_meta_q   <= spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_dly_q    <= cs_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sck_rise = sck_sync_q & ~sck_dly_q;
  assign sck_fall = ~sck_sync_q & sck_dly_q;
  assign cs_fall  = ~cs_sync_q & cs_dly_q;
  assign cs_rise  = cs_sync_q & ~cs_dly_q;

  assign ctrl_wr   = req_valid && req_write && (req_addr[7:0] == REG_CTRL);
  assign status_wr = req_valid && req_write && (req_addr[7:0] == REG_STATUS);
  assign txdata_wr = req_valid && req_write && (req_addr[7:0] == REG_TXDATA);
  assign rxdata_rd = req_valid && !req_write && (req_addr[7:0] == REG_RXDATA);
  assign flush     = ctrl_wr && req_wdata[CTRL_RX_FLUSH];
  assign pop_fire  = rxdata_rd && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    reload_d   = reload_q;
    tx_hold_d  = tx_hold_q;
    tx_pend_d  = tx_pend_q;
    en_d       = en_q;
    rx_ie_d    = rx_ie_q;
    rx_ovf_d   = rx_ovf_q;
    tx_udr_d   = tx_udr_q;
    push       = 1'b0;
    push_data  = {rx_shift_q, mosi_sync_q};
    load       = 1'b0;

    // Sticky clears first so a coincident set event below wins.
    if (status_wr && req_wdata[ST_RX_OVF]) rx_ovf_d = 1'b0;
    if (status_wr && req_wdata[ST_TX_UDR]) tx_udr_d = 1'b0;

    unique case (state_q)
      FRAME_IDLE: begin
        if (en_q && cs_fall) begin
          state_d   = FRAME_ACTIVE;
          bit_cnt_d = '0;
          load      = 1'b1;
        end
      end
      FRAME_ACTIVE: begin
        if (!en_q || cs_rise) begin
          state_d   = FRAME_IDLE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_sync_q};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push     = 1'b1;
            reload_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (reload_q) begin
            load     = 1'b1;
            reload_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = FRAME_IDLE;
    endcase

    if (load) begin
      if (tx_pend_q) begin
        tx_shift_d = tx_hold_q;
        tx_pend_d  = 1'b0;
      end else begin
        tx_shift_d = IDLE_BYTE;
        tx_udr_d   = 1'b1;
      end
    end

    // A TXDATA write lands after any same-cycle load, arming the following byte.
    if (txdata_wr) begin
      tx_hold_d = req_wdata[7:0];
      tx_pend_d = 1'b1;
    end
    if (ctrl_wr) begin
      en_d    = req_wdata[CTRL_EN];
      rx_ie_d = req_wdata[CTRL_RX_IE];
    end
    if (push && fifo_full && !pop_fire && !flush) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FRAME_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      reload_q   <= 1'b0;
      tx_hold_q  <= '0;
      tx_pend_q  <= 1'b0;
      en_q       <= 1'b0;
      rx_ie_q    <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_udr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      reload_q   <= reload_d;
      tx_hold_q  <= tx_hold_d;
      tx_pend_q  <= tx_pend_d;
      en_q       <= en_d;
      rx_ie_q    <= rx_ie_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_udr_q   <= tx_udr_d;
    end
  end

  spi_target_rxfifo #(.DEPTH(RX_DEPTH)) u_rxfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop_fire),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign spi_miso    = (state_q == FRAME_ACTIVE) ? tx_shift_q[7] : 1'b0;
  assign spi_miso_oe = (state_q == FRAME_ACTIVE);
  assign irq         = en_q & rx_ie_q & ~fifo_empty;

  always_comb begin
    rdata = '0;
    case (req_addr[7:0])
      REG_CTRL: begin
        rdata[CTRL_EN]    = en_q;
        rdata[CTRL_RX_IE] = rx_ie_q;
      end
      REG_STATUS: begin
        rdata[ST_BUSY]     = ~cs_sync_q & en_q;
        rdata[ST_RX_VALID] = ~fifo_empty;
        rdata[ST_RX_FULL]  = fifo_full;
        rdata[ST_TX_EMPTY] = ~tx_pend_q;
        rdata[ST_RX_OVF]   = rx_ovf_q;
        rdata[ST_TX_UDR]   = tx_udr_q;
      end
      REG_TXDATA: rdata[7:0] = tx_hold_q;
      REG_RXDATA: rdata[7:0] = fifo_empty ? 8'h00 : fifo_head;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a bit-banged Mode 0 master plus a bus driver
// feed observations to a monitor that compares them against a transaction-level model.
module tb_spi_target;
  import spi_pkg::*;

  localparam int RX_DEPTH = 4;
  localparam int HALF     = 4;  // sck half period in clk cycles (f_clk = 8 * f_sck)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = 4'hF;
  logic [31:0] rdata;
  logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, irq;

  spi_target #(.RX_DEPTH(RX_DEPTH), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rdata(rdata),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  int total = 0;
  int bad   = 0;

  // Transaction-level reference model
  logic [7:0] m_fifo[$];
  logic [7:0] m_hold = 8'h00;
  bit         m_pend = 0, m_ovf = 0, m_udr = 0, m_en = 0, m_ie = 0;
  logic [7:0] mtx[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  task automatic sb_expect(input string name, input logic [31:0] v);
    item_t it;
    it.name = name;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic sb_observe(input string name, input logic [31:0] v);
    item_t it;
    it.name = name;
    it.val  = v;
    obs_q.push_back(it);
  endtask

  // Monitor: pairs each DUT observation with the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk);
      while (obs_q.size() > 0) begin
        item_t o, e;
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL %s: observed 0x%0h with no expectation", o.name, o.val);
        end else begin
          e = exp_q.pop_front();
          check(e.name, o.val, e.val);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[ST_RX_VALID] = (m_fifo.size() > 0);
    s[ST_RX_FULL]  = (m_fifo.size() == RX_DEPTH);
    s[ST_TX_EMPTY] = !m_pend;
    s[ST_RX_OVF]   = m_ovf;
    s[ST_TX_UDR]   = m_udr;
    return s;
  endfunction

  task automatic m_load(output logic [7:0] b);
    if (m_pend) begin
      b = m_hold;
      m_pend = 0;
    end else begin
      b = 8'hFF;
      m_udr = 1;
    end
  endtask

  task automatic m_push(input logic [7:0] b);
    if (m_fifo.size() < RX_DEPTH) m_fifo.push_back(b);
    else m_ovf = 1;
  endtask

  // A frame loads once at CS fall and again after every completed byte.
  task automatic m_frame(input int nbytes);
    logic [7:0] t;
    m_load(t);
    for (int i = 0; i < nbytes; i++) begin
      sb_expect("master_rx", {24'h0, t});
      m_push(mtx[i]);
      m_load(t);
    end
  endtask

  task automatic m_reset();
    m_fifo.delete();
    m_hold = 8'h00;
    m_pend = 0; m_ovf = 0; m_udr = 0; m_en = 0; m_ie = 0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1;
    req_addr  = {24'h0, a}; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input string name, input logic [31:0] expv);
    sb_expect(name, expv);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    req_addr  = {24'h0, a};
    #1 sb_observe(name, rdata);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    bus_write(REG_CTRL, d);
    m_en = d[CTRL_EN];
    m_ie = d[CTRL_RX_IE];
    if (d[CTRL_RX_FLUSH]) m_fifo.delete();
  endtask

  task automatic wr_tx(input logic [7:0] b);
    bus_write(REG_TXDATA, {24'h0, b});
    m_hold = b;
    m_pend = 1;
  endtask

  task automatic w1c(input logic [31:0] d);
    bus_write(REG_STATUS, d);
    if (d[ST_RX_OVF]) m_ovf = 0;
    if (d[ST_TX_UDR]) m_udr = 0;
  endtask

  task automatic rd_status();
    bus_read(REG_STATUS, "status", m_status());
  endtask

  task automatic rd_rx();
    logic [31:0] e;
    e = (m_fifo.size() > 0) ? {24'h0, m_fifo.pop_front()} : 32'h0;
    bus_read(REG_RXDATA, "rxdata", e);
  endtask

  task automatic pin_check(input string name, input logic act, input logic expv);
    sb_expect(name, {31'h0, expv});
    sb_observe(name, {31'h0, act});
  endtask

  // Mode 0 master: data changes while sck is low, miso sampled just before each rise.
  task automatic spi_frame(input int nbytes, input int extra_bits, input bit obs);
    logic [7:0] rx;
    int nb;
    rx = '0;
    spi_cs_n = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    for (int b = 0; b < nbytes + ((extra_bits > 0) ? 1 : 0); b++) begin
      nb = (b < nbytes) ? 8 : extra_bits;
      for (int i = 0; i < nb; i++) begin
        spi_mosi = mtx[b][7-i];
        repeat (HALF) @(negedge clk);
        rx = {rx[6:0], spi_miso};
        spi_sck = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b0;
      end
      if (obs && b < nbytes) sb_observe("master_rx", {24'h0, rx});
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    pin_check("rst_miso", spi_miso, 1'b0);
    pin_check("rst_oe", spi_miso_oe, 1'b0);
    pin_check("rst_irq", irq, 1'b0);
    rd_status();
    bus_read(REG_CTRL, "ctrl_rst", 32'h0);
    rd_rx();

    // T1: loopback byte
    wr_ctrl(32'h3);
    wr_tx(8'hA5);
    mtx[0] = 8'h3C;
    m_frame(1);
    spi_frame(1, 0, 1);
    @(negedge clk);
    pin_check("irq_set", irq, m_en && m_ie && (m_fifo.size() > 0));
    rd_status();
    bus_read(REG_TXDATA, "txdata_rb", {24'h0, m_hold});
    rd_rx();
    @(negedge clk);
    pin_check("irq_clr", irq, 1'b0);
    bus_write(8'h10, 32'hDEAD_BEEF);
    bus_read(8'h10, "unmapped", 32'h0);

    // T2: underrun and W1C of tx_udr
    w1c(32'h20);
    mtx[0] = 8'h12;
    m_frame(1);
    spi_frame(1, 0, 1);
    rd_status();
    w1c(32'h20);
    rd_status();
    rd_rx();

    // T3: overflow with 5 bytes in one frame
    for (int i = 0; i < 5; i++) mtx[i] = 8'(i + 1);
    m_frame(5);
    spi_frame(5, 0, 1);
    rd_status();
    for (int i = 0; i < 5; i++) rd_rx();
    w1c(32'h30);

    // T4: partial byte discarded, next byte intact
    mtx[0] = 8'hC0;
    m_frame(0);
    spi_frame(0, 3, 1);
    rd_status();
    mtx[0] = 8'h5A;
    m_frame(1);
    spi_frame(1, 0, 1);
    rd_rx();

    // T5: second TXDATA written mid-frame, after the first byte was loaded
    begin
      logic [7:0] t1, t2, t3;
      wr_tx(8'h11);
      mtx[0] = 8'h77; mtx[1] = 8'h88;
      m_load(t1);
      m_hold = 8'h22; m_pend = 1;
      m_push(mtx[0]);
      m_load(t2);
      m_push(mtx[1]);
      m_load(t3);
      sb_expect("oe_mid", 32'h1);
      sb_expect("master_rx", {24'h0, t1});
      sb_expect("master_rx", {24'h0, t2});
      fork
        spi_frame(2, 0, 1);
        begin
          repeat (30) @(negedge clk);
          bus_write(REG_TXDATA, 32'h22);
          @(negedge clk);
          sb_observe("oe_mid", {31'h0, spi_miso_oe});
        end
      join
      rd_rx();
      rd_rx();
      rd_status();
    end

    // Randomized frames
    for (int it = 0; it < 16; it++) begin
      int nbytes, act;
      if ($urandom_range(0, 3) != 0) wr_tx(8'($urandom));
      nbytes = $urandom_range(1, 3);
      for (int i = 0; i < nbytes; i++) mtx[i] = 8'($urandom);
      m_frame(nbytes);
      spi_frame(nbytes, 0, 1);
      @(negedge clk);
      pin_check("irq_rand", irq, m_en && m_ie && (m_fifo.size() > 0));
      rd_status();
      act = $urandom_range(0, 2);
      if (act == 0) begin
        wr_ctrl(32'h7);
        rd_status();
      end else if (act == 1) begin
        for (int k = m_fifo.size(); k >= 0; k--) rd_rx();
      end
      if ($urandom_range(0, 1) == 1) w1c(32'h30);
    end

    // T6: reset pulse in the middle of a byte
    wr_ctrl(32'h3);
    wr_tx(8'h96);
    mtx[0] = 8'hE1;
    fork
      spi_frame(1, 0, 0);
      begin
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        pin_check("t6_miso", spi_miso, 1'b0);
        pin_check("t6_oe", spi_miso_oe, 1'b0);
        pin_check("t6_irq", irq, 1'b0);
      end
    join
    rd_status();
    rd_rx();
    wr_ctrl(32'h3);
    wr_tx(8'h3E);
    mtx[0] = 8'h4D;
    m_frame(1);
    spi_frame(1, 0, 1);
    rd_status();
    rd_rx();

    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      item_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: no observation, want 0x%0h", e.name, e.val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
